sdp_bram_bist: RTL and testbench

Built-in self-test initiator for a simple-dual-port block RAM with byte-enable writes. It sits on the RAM side opposite the array and drives the write port (wa/wd/we/be) and the read port (ra/re). It samples read data and compares it against expected patterns. It reports pass/fail, the first failing address and a saturating error count. The test covers both full-word writes and partial byte-enable writes.

---
 rtl/sdp_bram_bist.sv | 154 +++++++++++++++
 tb/tb_sdp_bram_bist.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/sdp_bram_bist.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : sdp_bram_bist                                                    |
// | Brief   : BIST initiator for a simple-dual-port BRAM with byte enables.    |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module sdp_bram_bist #(
  parameter int ABITS     = 10,
  parameter int DEPTH     = 1024,
  parameter int BYTEWIDTH = 8,
  parameter int NBYTES    = 4,
  parameter int ECBITS    = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  output logic                        pass,
  output logic [ECBITS-1:0]           err_count,
  output logic [ABITS-1:0]            first_err_addr,
  output logic [ABITS-1:0]            wa,
  output logic [NBYTES*BYTEWIDTH-1:0] wd,
  output logic                        we,
  output logic [NBYTES-1:0]           be,
  output logic [ABITS-1:0]            ra,
  output logic                        re,
  input  logic [NBYTES*BYTEWIDTH-1:0] rd
);

  localparam int                DBITS     = NBYTES * BYTEWIDTH;
  localparam logic [ABITS-1:0]  c_last    = ABITS'(DEPTH - 1);
  localparam logic [ECBITS-1:0] c_err_max = '1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WR_A = 3'd1,
    S_RD_A = 3'd2,
    S_DR_A = 3'd3,
    S_WR_B = 3'd4,
    S_RD_B = 3'd5,
    S_DR_B = 3'd6,
    S_DONE = 3'd7
  } state_t;

  state_t             r_state, w_state_n;
  logic [ABITS-1:0]   r_addr, w_addr_n;
  logic               r_pv, r_pb;
  logic [ABITS-1:0]   r_paddr;
  logic               w_wr, w_rd, w_in_b, w_mis;
  logic [DBITS-1:0]   w_exp;

  function automatic logic [DBITS-1:0] pat_a(input logic [ABITS-1:0] a);
    logic [DBITS-1:0] p;
    p = '0;
    for (int i = 0; i < NBYTES; i++)
      p[i*BYTEWIDTH +: BYTEWIDTH] = BYTEWIDTH'(a) + BYTEWIDTH'(i);
    return p;
  endfunction

  // Even addresses enable lanes 0,2,..; odd addresses enable lanes 1,3,..
  function automatic logic [NBYTES-1:0] mask_b(input logic [ABITS-1:0] a);
    logic [NBYTES-1:0] m;
    m = '0;
    for (int i = 0; i < NBYTES; i++)
      m[i] = ((i % 2) == 1) == a[0];
    return m;
  endfunction

  function automatic logic [DBITS-1:0] lane_bits(input logic [NBYTES-1:0] m);
    logic [DBITS-1:0] b;
    b = '0;
    for (int i = 0; i < NBYTES; i++)
      b[i*BYTEWIDTH +: BYTEWIDTH] = {BYTEWIDTH{m[i]}};
    return b;
  endfunction

  always_comb begin
    w_state_n = r_state;
    w_addr_n  = r_addr;
    case (r_state)
      S_IDLE: if (start) begin w_state_n = S_WR_A; w_addr_n = '0; end
      S_WR_A: if (r_addr == c_last) begin w_state_n = S_RD_A; w_addr_n = '0; end
              else w_addr_n = r_addr + 1'b1;
      S_RD_A: if (r_addr == c_last) begin w_state_n = S_DR_A; w_addr_n = '0; end
              else w_addr_n = r_addr + 1'b1;
      S_DR_A: begin w_state_n = S_WR_B; w_addr_n = '0; end
      S_WR_B: if (r_addr == c_last) begin w_state_n = S_RD_B; w_addr_n = '0; end
              else w_addr_n = r_addr + 1'b1;
      S_RD_B: if (r_addr == c_last) begin w_state_n = S_DR_B; w_addr_n = '0; end
              else w_addr_n = r_addr + 1'b1;
      S_DR_B: w_state_n = S_DONE;
      S_DONE: w_state_n = S_IDLE;
      default: w_state_n = S_IDLE;
    endcase
  end

  assign w_wr   = (w_state_n == S_WR_A) || (w_state_n == S_WR_B);
  assign w_rd   = (w_state_n == S_RD_A) || (w_state_n == S_RD_B);
  assign w_in_b = (w_state_n == S_WR_B);

  // Unwritten lanes in phase B still hold the phase-A pattern.
  assign w_exp = pat_a(r_paddr) ^ (r_pb ? lane_bits(mask_b(r_paddr)) : '0);
  assign w_mis = r_pv && (rd != w_exp);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_addr         <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
      we             <= 1'b0;
      wa             <= '0;
      wd             <= '0;
      be             <= '0;
      re             <= 1'b0;
      ra             <= '0;
      r_pv           <= 1'b0;
      r_pb           <= 1'b0;
      r_paddr        <= '0;
    end else begin
      r_state <= w_state_n;
      r_addr  <= w_addr_n;
      busy    <= (w_state_n != S_IDLE);
      we      <= w_wr;
      wa      <= w_wr ? w_addr_n : '0;
      wd      <= w_wr ? (w_in_b ? ~pat_a(w_addr_n) : pat_a(w_addr_n)) : '0;
      be      <= w_wr ? (w_in_b ? mask_b(w_addr_n) : '1) : '0;
      re      <= w_rd;
      ra      <= w_rd ? w_addr_n : '0;
      r_pv    <= re;
      r_paddr <= ra;
      r_pb    <= (r_state == S_RD_B);
      if (r_state == S_IDLE && start) begin
        done           <= 1'b0;
        pass           <= 1'b0;
        err_count      <= '0;
        first_err_addr <= '0;
      end else if (w_mis) begin
        if (err_count != c_err_max) err_count <= err_count + 1'b1;
        if (err_count == '0) first_err_addr <= r_paddr;
      end
      if (r_state == S_DONE) begin
        done <= 1'b1;
        pass <= (err_count == '0);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sdp_bram_bist.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_sdp_bram_bist                                                 |
// | Brief   : Bench for sdp_bram_bist with a fault-injecting BRAM model.       |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_sdp_bram_bist;
  localparam int AB = 10, DEPTH = 16, BW = 8, NB = 4, DB = NB * BW;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  always #5 clk = ~clk;

  logic          busy, done, pass, we, re;
  logic [15:0]   err_count;
  logic [AB-1:0] first_err_addr, wa, ra;
  logic [DB-1:0] wd, rd;
  logic [NB-1:0] be;

  logic          busy3, done3, pass3, we3, re3;
  logic [2:0]    err_count3;
  logic [AB-1:0] fea3, wa3, ra3;
  logic [DB-1:0] wd3, rd3;
  logic [NB-1:0] be3;

  sdp_bram_bist #(.ABITS(AB), .DEPTH(DEPTH), .BYTEWIDTH(BW), .NBYTES(NB), .ECBITS(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_err_addr(first_err_addr), .wa(wa), .wd(wd), .we(we),
    .be(be), .ra(ra), .re(re), .rd(rd));

  sdp_bram_bist #(.ABITS(AB), .DEPTH(DEPTH), .BYTEWIDTH(BW), .NBYTES(NB), .ECBITS(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy3), .done(done3), .pass(pass3),
    .err_count(err_count3), .first_err_addr(fea3), .wa(wa3), .wd(wd3), .we(we3),
    .be(be3), .ra(ra3), .re(re3), .rd(rd3));

  // mode 0: ideal, 1: bit 3 of word 5 stuck at 1, 2: byte enables ignored
  int            mode = 0;
  int            wcnt = 0;
  logic [DB-1:0] mem  [1024];
  logic [DB-1:0] mem3 [1024];

  initial begin
    for (int i = 0; i < 1024; i++) begin mem[i] = '0; mem3[i] = '0; end
  end

  always @(posedge clk) begin
    if (we) begin
      wcnt = wcnt + 1;
      for (int i = 0; i < NB; i++)
        if (be[i] || mode == 2) mem[wa][i*BW +: BW] <= wd[i*BW +: BW];
    end
    if (re) rd <= (mode == 1 && ra == 5) ? (mem[ra] | 32'h8) : mem[ra];
    if (we3) mem3[wa3] <= wd3;
    if (re3) rd3 <= mem3[ra3];
  end

  int errors = 0, checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    int mode;
    int exp_err;
    int exp_fea;
    bit exp_pass;
    bit chk3;
  } vec_t;

  vec_t vecs[4];
  vec_t sb[$];

  task automatic run_vec(input vec_t v, input int poke);
    int   cyc;
    bit   seen;
    vec_t e;
    mode = v.mode;
    @(negedge clk);
    wcnt  = 0;
    start = 1'b1;
    sb.push_back(v);
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    seen = 0; cyc = 0;
    while (!seen && cyc < 300) begin
      @(posedge clk); cyc++;
      #1;
      start = (cyc == poke);
      if (done) seen = 1;
    end
    start = 1'b0;
    chk("done_seen", seen, 1);
    chk("latency", cyc, 67);
    e = sb.pop_front();
    chk("pass", pass, e.exp_pass);
    chk("err_count", err_count, e.exp_err);
    chk("first_err_addr", first_err_addr, e.exp_fea);
    chk("write_cycles", wcnt, 2 * DEPTH);
    chk("busy_at_done", busy, 0);
    if (e.chk3) begin
      chk("err_count_sat", err_count3, 7);
      chk("pass_sat", pass3, 0);
    end
  endtask

  initial begin
    int cyc;
    bit seen;
    vecs[0] = '{0, 0,  0, 1'b1, 1'b0};
    vecs[1] = '{1, 2,  5, 1'b0, 1'b0};
    vecs[2] = '{2, 16, 0, 1'b0, 1'b1};
    vecs[3] = '{0, 0,  0, 1'b1, 1'b0};

    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err", err_count, 0);
    chk("rst_fea", first_err_addr, 0);
    chk("rst_we_re", {we, re}, 0);
    chk("rst_be", be, 0);
    chk("rst_wa_ra", {wa, ra}, 0);
    chk("rst_wd", wd, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 4; i++) run_vec(vecs[i], -1);

    // start re-pulsed mid-run must not restart the test
    run_vec(vecs[0], 10);

    // start held high: one IDLE cycle between back-to-back runs
    mode = 0;
    @(negedge clk); start = 1'b1;
    seen = 0; cyc = 0;
    while (!seen && cyc < 300) begin
      @(posedge clk); cyc++; #1;
      if (done) seen = 1;
    end
    chk("b2b_done", seen, 1);
    chk("b2b_idle_gap", busy, 0);
    @(posedge clk); #1;
    chk("b2b_restart_busy", busy, 1);
    chk("b2b_done_cleared", done, 0);
    start = 1'b0;
    cyc = 0;
    while (busy && cyc < 300) begin @(posedge clk); cyc++; #1; end
    chk("b2b_finished", busy, 0);

    // asynchronous reset in the middle of a run
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (20) @(posedge clk);
    #1; rst_n = 1'b0; #1;
    chk("abort_busy", busy, 0);
    chk("abort_we_re", {we, re}, 0);
    wcnt = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_no_writes", wcnt, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("abort_done", done, 0);
    chk("abort_err", err_count, 0);
    run_vec(vecs[3], -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
